pieo_post_deq_dispatcher: RTL and testbench

Dequeue-side companion to the PIEO pre-enqueue shaper. It issues dequeue requests to the PIEO when any per-flow FIFO holds data, and receives the element `{send_time, rank, fifo_id}`. It holds the element until its send time is reached, then grants the selected FIFO the egress AXI-stream for exactly one packet, ending on the tlast beat. It sits between the PIEO output port and the egress FIFO mux.

---
 rtl/pieo_post_deq_dispatcher.sv | 188 ++++++++++++++++++
 tb/tb_pieo_post_deq_dispatcher.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pieo_post_deq_dispatcher.sv
// Dequeue-side dispatcher for the PIEO scheduler. It requests elements from
// the PIEO, holds each element until its send time, then grants the chosen
// per-flow FIFO the egress stream for one packet.
module pieo_post_deq_dispatcher #(
    parameter int NUM_FIFO       = 3,
    parameter int ID_LOG         = 2,
    parameter int RANK_LOG       = 1,
    parameter int TIME_LOG       = 1,
    parameter int RESP_TIMEOUT   = 15,
    parameter int BACKOFF_CYCLES = 4,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [TIME_LOG-1:0]                curr_time,
    input  logic                               pieo_ready,
    output logic                               pieo_deq_trigger,
    output logic [TIME_LOG-1:0]                pieo_deq_time,
    input  logic                               pieo_deq_valid,
    input  logic                               pieo_deq_empty,
    input  logic [ID_LOG+RANK_LOG+TIME_LOG-1:0] pieo_deq_element,
    input  logic [NUM_FIFO-1:0]                fifo_not_empty,
    output logic [NUM_FIFO-1:0]                fifo_release,
    input  logic                               tx_tvalid,
    input  logic                               tx_tready,
    input  logic                               tx_tlast,
    output logic                               busy,
    output logic [CNT_WIDTH-1:0]               pkt_count,
    output logic [CNT_WIDTH-1:0]               err_count
);

    localparam int TMR_MAX = (RESP_TIMEOUT > BACKOFF_CYCLES) ? RESP_TIMEOUT : BACKOFF_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_RESP,
        S_HOLD,
        S_SEND,
        S_BACKOFF
    } state_t;

    function automatic logic [NUM_FIFO-1:0] f_onehot(input logic [ID_LOG-1:0] id);
        logic [NUM_FIFO-1:0] oh;
        oh = '0;
        for (int unsigned i = 0; i < NUM_FIFO; i++) begin
            if (32'(id) == i) oh[i] = 1'b1;
        end
        return oh;
    endfunction

    state_t                r_state;
    state_t                w_next;
    logic [TMR_W-1:0]      r_timer;
    logic [ID_LOG-1:0]     r_id;
    logic [RANK_LOG-1:0]   r_rank;
    logic [TIME_LOG-1:0]   r_send_time;
    logic                  r_trigger;
    logic [TIME_LOG-1:0]   r_deq_time;
    logic [NUM_FIFO-1:0]   r_release;
    logic                  r_busy;
    logic [CNT_WIDTH-1:0]  r_pkt;
    logic [CNT_WIDTH-1:0]  r_err;

    logic [ID_LOG-1:0]     w_resp_id;
    logic [RANK_LOG-1:0]   w_resp_rank;
    logic [TIME_LOG-1:0]   w_resp_time;
    logic [TIME_LOG-1:0]   w_resp_diff;
    logic [TIME_LOG-1:0]   w_hold_diff;
    logic                  w_resp_elig;
    logic                  w_hold_elig;
    logic                  w_resp_ok;
    logic                  w_latch;
    logic [ID_LOG-1:0]     w_grant_id;
    logic                  w_last_beat;
    logic                  w_discard;
    logic                  w_timeout;
    logic                  w_unused_rank;

    assign w_resp_id   = pieo_deq_element[ID_LOG-1:0];
    assign w_resp_rank = pieo_deq_element[ID_LOG +: RANK_LOG];
    assign w_resp_time = pieo_deq_element[ID_LOG+RANK_LOG +: TIME_LOG];

    // Modular difference: MSB clear means send_time is at or behind curr_time.
    assign w_resp_diff = curr_time - w_resp_time;
    assign w_hold_diff = curr_time - r_send_time;
    assign w_resp_elig = ~w_resp_diff[TIME_LOG-1];
    assign w_hold_elig = ~w_hold_diff[TIME_LOG-1];

    // An out-of-range id yields an all-zero one-hot, so it is discarded too.
    assign w_resp_ok   = |(f_onehot(w_resp_id) & fifo_not_empty);
    assign w_latch     = (r_state == S_WAIT_RESP) && pieo_deq_valid && !pieo_deq_empty;
    assign w_grant_id  = w_latch ? w_resp_id : r_id;
    assign w_last_beat = tx_tvalid && tx_tready && tx_tlast;

    // Rank travels with the element but does not affect dispatch.
    assign w_unused_rank = ^r_rank;

    // Next-state decode and error events.
    always_comb begin
        w_next    = r_state;
        w_discard = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            S_IDLE:      if (pieo_ready && |fifo_not_empty) w_next = S_REQ;
            S_REQ:       w_next = S_WAIT_RESP;
            S_WAIT_RESP: begin
                if (pieo_deq_valid) begin
                    if (pieo_deq_empty) begin
                        w_next = S_BACKOFF;
                    end else if (!w_resp_ok) begin
                        w_discard = 1'b1;
                        w_next    = S_IDLE;
                    end else if (w_resp_elig) begin
                        w_next = S_SEND;
                    end else begin
                        w_next = S_HOLD;
                    end
                end else if (r_timer == TMR_W'(RESP_TIMEOUT - 1)) begin
                    w_timeout = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            S_HOLD:      if (w_hold_elig) w_next = S_SEND;
            S_SEND:      if (w_last_beat) w_next = S_IDLE;
            S_BACKOFF:   if (r_timer == TMR_W'(BACKOFF_CYCLES - 1)) w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    // State register, dwell timer and latched element.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_id        <= '0;
            r_rank      <= '0;
            r_send_time <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) begin
                r_timer <= '0;
            end else if (r_state == S_WAIT_RESP || r_state == S_BACKOFF) begin
                r_timer <= r_timer + 1'b1;
            end
            if (w_latch) begin
                r_id        <= w_resp_id;
                r_rank      <= w_resp_rank;
                r_send_time <= w_resp_time;
            end
        end
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_trigger  <= 1'b0;
            r_deq_time <= '0;
            r_release  <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_trigger  <= (w_next == S_REQ);
            r_deq_time <= (w_next == S_REQ) ? curr_time : '0;
            r_release  <= (w_next == S_SEND) ? f_onehot(w_grant_id) : '0;
            r_busy     <= (w_next != S_IDLE);
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pkt <= '0;
            r_err <= '0;
        end else begin
            if (r_state == S_SEND && w_last_beat && r_pkt != '1) r_pkt <= r_pkt + 1'b1;
            if ((w_discard || w_timeout) && r_err != '1) r_err <= r_err + 1'b1;
        end
    end

    assign pieo_deq_trigger = r_trigger;
    assign pieo_deq_time    = r_deq_time;
    assign fifo_release     = r_release;
    assign busy             = r_busy;
    assign pkt_count        = r_pkt;
    assign err_count        = r_err;

endmodule

// File: tb/tb_pieo_post_deq_dispatcher.sv
// Directed bench for pieo_post_deq_dispatcher (TIME_LOG=4, CNT_WIDTH=4).
module tb_pieo_post_deq_dispatcher;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] curr_time;
    logic       pieo_ready;
    logic       pieo_deq_trigger;
    logic [3:0] pieo_deq_time;
    logic       pieo_deq_valid;
    logic       pieo_deq_empty;
    logic [6:0] pieo_deq_element;
    logic [2:0] fifo_not_empty;
    logic [2:0] fifo_release;
    logic       tx_tvalid, tx_tready, tx_tlast;
    logic       busy;
    logic [3:0] pkt_count;
    logic [3:0] err_count;

    int n_checks = 0;
    int n_fail   = 0;

    pieo_post_deq_dispatcher #(
        .NUM_FIFO(3), .ID_LOG(2), .RANK_LOG(1), .TIME_LOG(4),
        .RESP_TIMEOUT(15), .BACKOFF_CYCLES(4), .CNT_WIDTH(4)
    ) dut (
        .clk(clk), .rst(rst), .curr_time(curr_time), .pieo_ready(pieo_ready),
        .pieo_deq_trigger(pieo_deq_trigger), .pieo_deq_time(pieo_deq_time),
        .pieo_deq_valid(pieo_deq_valid), .pieo_deq_empty(pieo_deq_empty),
        .pieo_deq_element(pieo_deq_element), .fifo_not_empty(fifo_not_empty),
        .fifo_release(fifo_release), .tx_tvalid(tx_tvalid), .tx_tready(tx_tready),
        .tx_tlast(tx_tlast), .busy(busy), .pkt_count(pkt_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] mk(input logic [3:0] st, input logic rk, input logic [1:0] id);
        return {st, rk, id};
    endfunction

    task automatic respond(input logic [6:0] e);
        pieo_deq_valid   = 1'b1;
        pieo_deq_empty   = 1'b0;
        pieo_deq_element = e;
    endtask

    task automatic beat(input logic last);
        tx_tvalid = 1'b1;
        tx_tready = 1'b1;
        tx_tlast  = last;
    endtask

    task automatic no_beat();
        tx_tvalid = 1'b0;
        tx_tready = 1'b0;
        tx_tlast  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b1; curr_time = '0; pieo_ready = 1'b0;
        pieo_deq_valid = 1'b0; pieo_deq_empty = 1'b0; pieo_deq_element = '0;
        fifo_not_empty = '0; no_beat();
        tick(); tick();
        chk("rst_trigger", 32'(pieo_deq_trigger), 32'd0);
        chk("rst_deq_time", 32'(pieo_deq_time), 32'd0);
        chk("rst_release", 32'(fifo_release), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pkt", 32'(pkt_count), 32'd0);
        chk("rst_err", 32'(err_count), 32'd0);
        rst = 1'b0;
        tick();

        // Basic dispatch: fifo 1, send_time 0 at time 0, three beats
        pieo_ready = 1'b1; fifo_not_empty = 3'b010;
        tick();
        chk("basic_trigger", 32'(pieo_deq_trigger), 32'd1);
        chk("basic_deq_time", 32'(pieo_deq_time), 32'd0);
        chk("basic_busy", 32'(busy), 32'd1);
        pieo_ready = 1'b0;
        tick();
        chk("basic_trigger_pulse", 32'(pieo_deq_trigger), 32'd0);
        respond(mk(4'd0, 1'b0, 2'd1));
        tick();
        chk("basic_grant", 32'(fifo_release), 32'b010);
        pieo_deq_valid = 1'b0;
        beat(1'b0);
        tick();
        chk("basic_beat1", 32'(fifo_release), 32'b010);
        tick();
        chk("basic_beat2", 32'(fifo_release), 32'b010);
        beat(1'b1);
        tick();
        chk("basic_release_off", 32'(fifo_release), 32'd0);
        chk("basic_pkt", 32'(pkt_count), 32'd1);
        chk("basic_idle", 32'(busy), 32'd0);
        no_beat();

        // HOLD across wrap: curr_time 14, send_time 1
        curr_time = 4'd14; pieo_ready = 1'b1; fifo_not_empty = 3'b001;
        tick();
        chk("wrap_deq_time", 32'(pieo_deq_time), 32'd14);
        pieo_ready = 1'b0;
        tick();
        respond(mk(4'd1, 1'b0, 2'd0));
        tick();
        chk("wrap_hold_t14", 32'(fifo_release), 32'd0);
        chk("wrap_hold_busy", 32'(busy), 32'd1);
        pieo_deq_valid = 1'b0; curr_time = 4'd15;
        tick();
        chk("wrap_hold_t15", 32'(fifo_release), 32'd0);
        curr_time = 4'd0;
        tick();
        chk("wrap_hold_t0", 32'(fifo_release), 32'd0);
        curr_time = 4'd1;
        tick();
        chk("wrap_grant_t1", 32'(fifo_release), 32'b001);
        beat(1'b1); pieo_ready = 1'b1;
        tick();
        chk("wrap_release_off", 32'(fifo_release), 32'd0);
        chk("wrap_pkt", 32'(pkt_count), 32'd2);
        chk("wrap_no_trigger_e1", 32'(pieo_deq_trigger), 32'd0);
        no_beat();
        tick();
        chk("b2b_trigger_e2", 32'(pieo_deq_trigger), 32'd1);
        chk("b2b_deq_time", 32'(pieo_deq_time), 32'd1);
        pieo_ready = 1'b0; curr_time = 4'd14;
        tick();
        respond(mk(4'd13, 1'b1, 2'd0));
        tick();
        chk("elig_grant_immediate", 32'(fifo_release), 32'b001);
        pieo_deq_valid = 1'b0; beat(1'b1);
        tick();
        chk("elig_pkt", 32'(pkt_count), 32'd3);
        no_beat();

        // Empty response -> backoff, next trigger 6 cycles after response
        pieo_ready = 1'b1; fifo_not_empty = 3'b100;
        tick();
        chk("empty_trigger", 32'(pieo_deq_trigger), 32'd1);
        tick();
        pieo_deq_valid = 1'b1; pieo_deq_empty = 1'b1;
        tick();
        chk("backoff_busy", 32'(busy), 32'd1);
        pieo_deq_valid = 1'b0; pieo_deq_empty = 1'b0;
        tick(); tick(); tick();
        chk("backoff_r4_busy", 32'(busy), 32'd1);
        chk("backoff_r4_trigger", 32'(pieo_deq_trigger), 32'd0);
        tick();
        chk("backoff_r5_idle", 32'(busy), 32'd0);
        chk("backoff_r5_trigger", 32'(pieo_deq_trigger), 32'd0);
        tick();
        chk("backoff_r6_trigger", 32'(pieo_deq_trigger), 32'd1);
        chk("backoff_pkt", 32'(pkt_count), 32'd3);
        chk("backoff_err", 32'(err_count), 32'd0);

        // Invalid element: id 3 out of range
        pieo_ready = 1'b0;
        tick();
        respond(mk(4'd0, 1'b0, 2'd3));
        tick();
        chk("bad_id_err", 32'(err_count), 32'd1);
        chk("bad_id_release", 32'(fifo_release), 32'd0);
        chk("bad_id_idle", 32'(busy), 32'd0);
        pieo_deq_valid = 1'b0;

        // Invalid element: id 0 but fifo 0 empty
        pieo_ready = 1'b1;
        tick();
        pieo_ready = 1'b0;
        tick();
        respond(mk(4'd0, 1'b0, 2'd0));
        tick();
        chk("empty_fifo_err", 32'(err_count), 32'd2);
        chk("empty_fifo_release", 32'(fifo_release), 32'd0);
        pieo_deq_valid = 1'b0;

        // Response strobe while IDLE is ignored
        respond(mk(4'd0, 1'b0, 2'd2));
        tick();
        chk("stray_valid_busy", 32'(busy), 32'd0);
        chk("stray_valid_err", 32'(err_count), 32'd2);
        chk("stray_valid_release", 32'(fifo_release), 32'd0);
        pieo_deq_valid = 1'b0;

        // Timeout: IDLE decision at t, back to IDLE at t+17
        pieo_ready = 1'b1;
        tick();
        pieo_ready = 1'b0;
        repeat (15) tick();
        chk("timeout_t16_busy", 32'(busy), 32'd1);
        chk("timeout_t16_err", 32'(err_count), 32'd2);
        tick();
        chk("timeout_t17_idle", 32'(busy), 32'd0);
        chk("timeout_t17_err", 32'(err_count), 32'd3);

        // Response on the expiry cycle is accepted
        pieo_ready = 1'b1;
        tick();
        pieo_ready = 1'b0;
        repeat (15) tick();
        respond(mk(4'd14, 1'b0, 2'd2));
        tick();
        chk("expiry_grant", 32'(fifo_release), 32'b100);
        chk("expiry_err", 32'(err_count), 32'd3);
        pieo_deq_valid = 1'b0;
        beat(1'b0);
        tick();
        chk("send_no_tlast", 32'(fifo_release), 32'b100);

        // Reset mid-SEND
        rst = 1'b1;
        tick();
        chk("midrst_release", 32'(fifo_release), 32'd0);
        chk("midrst_pkt", 32'(pkt_count), 32'd0);
        chk("midrst_err", 32'(err_count), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        rst = 1'b0; no_beat();
        tick();

        // Saturation: 18 dispatches, pkt_count stops at 15
        curr_time = 4'd0; fifo_not_empty = 3'b001;
        for (int k = 0; k < 18; k++) begin
            pieo_ready = 1'b1;
            tick();
            pieo_ready = 1'b0;
            tick();
            respond(mk(4'd0, 1'b0, 2'd0));
            tick();
            pieo_deq_valid = 1'b0;
            beat(1'b1);
            tick();
            no_beat();
            chk($sformatf("sat_pkt_%0d", k), 32'(pkt_count), (k + 1 < 15) ? 32'(k + 1) : 32'd15);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
